// File: rtl/tcl_sched_pkg.sv
// Shared types and helpers for the transaction-layer pop scheduler.
package tcl_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    RUN    = 2'd2
  } sched_state_e;

  localparam int N_PORTS = 4;
  localparam int DATA_W  = 12;

  function automatic logic [1:0] next_port(input logic [1:0] port);
    return port + 2'd1;
  endfunction

endpackage

// File: rtl/sched_delay_line.sv
// Fixed-depth shift register carrying {valid, idx} from a pop to its matching push.
module sched_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [1:0] in_idx,
  output logic       out_valid,
  output logic [1:0] out_idx,
  output logic       busy
);

  logic [DEPTH-1:0] valid_r;
  logic [1:0]       idx_r [DEPTH];

  // shift stage 0 toward stage DEPTH-1; reset discards anything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        idx_r[i] <= 2'd0;
      end
    end else begin
      valid_r[0] <= in_valid;
      idx_r[0]   <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        idx_r[i]   <= idx_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[DEPTH-1];
  assign out_idx   = idx_r[DEPTH-1];
  assign busy      = |valid_r;

endmodule

// File: rtl/wrr_pop_scheduler.sv
// Weighted round-robin pop scheduler: pops one input FIFO per cycle and pushes
// the word into the same port's output FIFO POP_LATENCY cycles later.
module wrr_pop_scheduler #(
  parameter int DATA_W      = 12,
  parameter int WEIGHT_W    = 3,
  parameter int POP_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  enable,
  input  logic [4*WEIGHT_W-1:0] weights,
  input  logic [3:0]            empty,
  input  logic [3:0]            almost_full,
  input  logic [4*DATA_W-1:0]   data_in,
  output logic [3:0]            pop,
  output logic [3:0]            push,
  output logic [DATA_W-1:0]     data_out,
  output logic [1:0]            grant_idx,
  output logic                  busy
);

  import tcl_sched_pkg::*;

  sched_state_e          state_r;
  sched_state_e          state_nxt_s;
  logic [1:0]            ptr_r;
  logic [1:0]            ptr_nxt_s;
  logic [WEIGHT_W-1:0]   credit_r;
  logic [WEIGHT_W-1:0]   weight_r [N_PORTS];
  logic [N_PORTS-1:0]    elig_s;
  logic                  sched_s;
  logic [3:0]            pop_s;
  logic [1:0]            grant_idx_r;
  logic                  dl_valid_s;
  logic [1:0]            dl_idx_s;
  logic                  dl_busy_s;
  logic [3:0]            push_s;
  logic [DATA_W-1:0]     data_out_s;

  assign ptr_nxt_s = next_port(ptr_r);
  // init outranks enable, so a pending reconfiguration blocks new pops at once
  assign sched_s   = (state_r == RUN) && enable && !init;

  // per-port eligibility; a zero weight permanently disables the port
  always_comb begin
    elig_s = 4'b0000;
    for (int i = 0; i < N_PORTS; i++) begin
      elig_s[i] = !empty[i] && !almost_full[i] && (weight_r[i] != {WEIGHT_W{1'b0}});
    end
  end

  // Mealy pop of the port under the pointer
  always_comb begin
    pop_s = 4'b0000;
    if (sched_s && elig_s[ptr_r]) begin
      pop_s = 4'b0001 << ptr_r;
    end else begin
      pop_s = 4'b0000;
    end
  end

  // next-state logic: init from any state wins
  always_comb begin
    state_nxt_s = state_r;
    if (init) begin
      state_nxt_s = CONFIG;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = IDLE;
        CONFIG:  state_nxt_s = RUN;
        RUN:     state_nxt_s = RUN;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // weight latch plus pointer/credit walk; credit is reloaded at 1 so it never wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r    <= 2'd0;
      credit_r <= {WEIGHT_W{1'b0}};
      for (int i = 0; i < N_PORTS; i++) begin
        weight_r[i] <= WEIGHT_W'(1);
      end
    end else if (state_r == CONFIG) begin
      for (int i = 0; i < N_PORTS; i++) begin
        weight_r[i] <= weights[i*WEIGHT_W +: WEIGHT_W];
      end
      ptr_r    <= 2'd0;
      credit_r <= weights[WEIGHT_W-1:0];
    end else if (sched_s) begin
      if (elig_s[ptr_r] && (credit_r > WEIGHT_W'(1))) begin
        credit_r <= credit_r - WEIGHT_W'(1);
      end else begin
        ptr_r    <= ptr_nxt_s;
        credit_r <= weight_r[ptr_nxt_s];
      end
    end
  end

  // most recent granted port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_idx_r <= 2'd0;
    end else if (pop_s != 4'b0000) begin
      grant_idx_r <= ptr_r;
    end
  end

  sched_delay_line #(
    .DEPTH (POP_LATENCY)
  ) u_delay_line (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (pop_s != 4'b0000),
    .in_idx    (ptr_r),
    .out_valid (dl_valid_s),
    .out_idx   (dl_idx_s),
    .busy      (dl_busy_s)
  );

  // push decode and data mux; data is forced to zero when nothing is pushed
  always_comb begin
    push_s     = 4'b0000;
    data_out_s = {DATA_W{1'b0}};
    if (dl_valid_s) begin
      push_s     = 4'b0001 << dl_idx_s;
      data_out_s = data_in[dl_idx_s*DATA_W +: DATA_W];
    end else begin
      push_s     = 4'b0000;
      data_out_s = {DATA_W{1'b0}};
    end
  end

  assign pop       = pop_s;
  assign push      = push_s;
  assign data_out  = data_out_s;
  assign grant_idx = grant_idx_r;
  assign busy      = dl_busy_s;

endmodule

// File: tb/tb_wrr_pop_scheduler.sv
// Directed-vector bench for wrr_pop_scheduler with hand-computed pop/push sequences.
module tb_wrr_pop_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic        enable;
  logic [11:0] weights;
  logic [3:0]  empty;
  logic [3:0]  almost_full;
  logic [47:0] data_in;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [11:0] data_out;
  logic [1:0]  grant_idx;
  logic        busy;

  int n_vec     = 0;
  int n_miss    = 0;
  int prev_port = -1;

  wrr_pop_scheduler #(
    .DATA_W      (12),
    .WEIGHT_W    (3),
    .POP_LATENCY (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .enable      (enable),
    .weights     (weights),
    .empty       (empty),
    .almost_full (almost_full),
    .data_in     (data_in),
    .pop         (pop),
    .push        (push),
    .data_out    (data_out),
    .grant_idx   (grant_idx),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] onehot(input int port);
    if (port < 0) return 4'b0000;
    return 4'b0001 << port;
  endfunction

  function automatic logic [11:0] word(input int port);
    case (port)
      0:       return 12'h123;
      1:       return 12'h456;
      2:       return 12'h789;
      3:       return 12'hABC;
      default: return 12'h000;
    endcase
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one cycle: check the Mealy pop and the push from the previous pop, then advance
  task automatic step(input string tag, input int exp_port);
    #1;
    check_vec({tag, ".pop"},  32'(pop),      32'(onehot(exp_port)));
    check_vec({tag, ".push"}, 32'(push),     32'(onehot(prev_port)));
    check_vec({tag, ".data"}, 32'(data_out), 32'(word(prev_port)));
    check_vec({tag, ".busy"}, 32'(busy),     32'(prev_port >= 0));
    if (prev_port >= 0) begin
      check_vec({tag, ".grant"}, 32'(grant_idx), 32'(prev_port));
    end
    @(posedge clk);
    @(negedge clk);
    prev_port = exp_port;
  endtask

  task automatic configure(input logic [11:0] w);
    init    = 1'b1;
    weights = w;
    step("cfg_init", -1);
    init = 1'b0;
    step("cfg_load", -1);
  endtask

  int seq_wrr  [10] = '{0, 0, 1, 2, 3, 0, 0, 1, 2, 3};
  int seq_empty[5]  = '{0, -1, 2, 3, 0};
  int seq_w0   [8]  = '{-1, 1, 2, 3, -1, 1, 2, 3};

  initial begin
    reset       = 1'b1;
    init        = 1'b0;
    enable      = 1'b0;
    weights     = 12'h000;
    empty       = 4'b0000;
    almost_full = 4'b0000;
    data_in     = {12'hABC, 12'h789, 12'h456, 12'h123};

    @(negedge clk);
    #1;
    check_vec("rst.pop",   32'(pop),       32'h0);
    check_vec("rst.push",  32'(push),      32'h0);
    check_vec("rst.data",  32'(data_out),  32'h0);
    check_vec("rst.grant", 32'(grant_idx), 32'h0);
    check_vec("rst.busy",  32'(busy),      32'h0);
    reset = 1'b0;
    @(negedge clk);

    // IDLE ignores enable until init
    enable = 1'b1;
    step("idle", -1);
    step("idle", -1);
    enable = 1'b0;

    // weights 2,1,1,1 with every port eligible
    configure({3'd1, 3'd1, 3'd1, 3'd2});
    enable = 1'b1;
    for (int k = 0; k < 10; k++) step("wrr", seq_wrr[k]);
    enable = 1'b0;
    step("wrr_drain", -1);
    step("wrr_quiet", -1);

    // enable low holds ptr and credit mid-quantum
    enable = 1'b1;
    step("hold_a", 0);
    enable = 1'b0;
    step("hold_off", -1);
    step("hold_off", -1);
    enable = 1'b1;
    step("hold_b", 0);
    step("hold_c", 1);

    // init with enable high in RUN suppresses the pop; then empty port 1 is skipped
    empty = 4'b0010;
    configure({3'd1, 3'd1, 3'd1, 3'd1});
    for (int k = 0; k < 5; k++) step("empty1", seq_empty[k]);
    enable = 1'b0;
    empty  = 4'b0000;
    step("empty1_drain", -1);

    // almost_full on port 2 while it still holds credit 3
    configure({3'd1, 3'd3, 3'd1, 3'd1});
    enable = 1'b1;
    step("af", 0);
    step("af", 1);
    almost_full = 4'b0100;
    step("af_block", -1);
    step("af_next", 3);
    enable = 1'b0;
    step("abc_push", -1);
    step("abc_quiet", -1);
    almost_full = 4'b0000;

    // weight 0 disables port 0
    enable = 1'b1;
    configure({3'd1, 3'd1, 3'd1, 3'd0});
    for (int k = 0; k < 8; k++) step("w0", seq_w0[k]);
    enable = 1'b0;
    step("w0_drain", -1);

    // reset while a push is in flight
    configure({3'd1, 3'd1, 3'd1, 3'd1});
    enable = 1'b1;
    step("pre_rst", 0);
    #1;
    check_vec("inflight.push", 32'(push), 32'h1);
    reset = 1'b1;
    #1;
    check_vec("mid_rst.pop",   32'(pop),       32'h0);
    check_vec("mid_rst.push",  32'(push),      32'h0);
    check_vec("mid_rst.busy",  32'(busy),      32'h0);
    check_vec("mid_rst.data",  32'(data_out),  32'h0);
    check_vec("mid_rst.grant", 32'(grant_idx), 32'h0);
    @(negedge clk);
    reset     = 1'b0;
    prev_port = -1;
    for (int k = 0; k < 3; k++) step("post_rst", -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
